// File: rtl/transmisor.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even parity, NB_STOP stop bits,
// each bit held for 16 ticks of the shared 16x baud strobe. Define TX_PARITY_EN to add the parity bit.
module transmisor #(
    parameter int NB_DATA       = 8,
    parameter int NB_STOP       = 2,
    parameter int NB_STOP_TICKS = 16*NB_STOP
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_tx,
    output logic               o_ready,
    output logic               o_done
);

    localparam int CNT_W = ($clog2(NB_STOP_TICKS) > 5) ? $clog2(NB_STOP_TICKS) : 5;
    localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(NB_STOP_TICKS-1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_DATA-1);

`ifdef TX_PARITY_EN
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    function automatic logic even_parity(input logic [NB_DATA-1:0] word);
        return ^word;
    endfunction

    logic par_r, par_n;
`else
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;
`endif

    state_t             state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [NB_DATA-1:0] shift_r, shift_n;
    logic               tx_r, tx_n;
    logic               ready_r, ready_n;
    logic               done_r, done_n;

    // Next-state, counter and datapath updates; ticks only advance the frame outside IDLE
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        shift_n = shift_r;
        done_n  = 1'b0;
`ifdef TX_PARITY_EN
        par_n   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    shift_n = i_data;
                    cnt_n   = '0;
                    state_n = START;
`ifdef TX_PARITY_EN
                    par_n   = even_parity(i_data);
`endif
                end else begin
                    cnt_n = cnt_r;
                end
            end
            START: begin
                if (i_tick && cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else if (i_tick) begin
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            DATA: begin
                if (i_tick && cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = shift_r >> 1;
                    if (idx_r == IDX_LAST) begin
`ifdef TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx_r + IDX_W'(1);
                    end
                end else if (i_tick) begin
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (i_tick && cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else if (i_tick) begin
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
`endif
            STOP: begin
                if (i_tick && cnt_r == STOP_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (i_tick) begin
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Line level is decoded from the upcoming state so o_tx can be a plain register
    always_comb begin
        tx_n    = 1'b1;
        ready_n = (state_n == IDLE);
        case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
`ifdef TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
            ready_r <= ready_n;
            done_r  <= done_n;
`ifdef TX_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    assign o_tx    = tx_r;
    assign o_ready = ready_r;
    assign o_done  = done_r;

endmodule
